cbm2_slot_sequencer: RTL and testbench
======================================

Name: cbm2_slot_sequencer

Overview:
- Parametrised system-cycle sequencer for the CBM-II core; replaces the hard-wired EXT/VID/CPU slot enum in the main block.
- Divides clk_sys into a repeating frame of EXT, VID and CPU slots, with configurable lengths and strobe offsets.
- Generates the CPU/VIC/IO enables, the IO write pulse, SDRAM CE/WE, and the io_cycle/refresh handshake to the SDRAM controller.
- Adds a runtime refresh divider, an independent video RAM request, and CPU wait-state (rdy) suppression.

Parameters:
EXT_LEN, 12, number of EXT slots (frame start)
VID_LEN, 4, number of VID slots
CPU_LEN, 16, number of CPU slots (frame end)
RFSH_OFS, 4, EXT slot index where the refresh window begins (must be >=1)
RFSH_LEN, 4, refresh window length in slots (RFSH_OFS+RFSH_LEN <= EXT_LEN)
CPU_EN_OFS, 2, CPU slot index of enable_cpu
WR_OFS, 12, CPU slot index of pulse_wr_io
IOP_OFS, 13, CPU slot index of enable_io_p

Ports:
clk_sys  in  1  system clock
reset_n  in  1  synchronous active-low reset
rfsh_div  in  4  refresh every rfsh_div+1 frames
vid_req  in  1  video wants RAM this frame (Professional model)
cpu_req  in  1  CPU access targets RAM (cs_ram)
cpu_we  in  1  CPU write
cpu_rdy  in  1  low = wait state, withhold enable_cpu
slot  out  SW  current slot, SW=$clog2(TOTAL), TOTAL=EXT_LEN+VID_LEN+CPU_LEN
frame_end  out  1  high in slot TOTAL-1
io_cycle  out  1  SDRAM free for external/IO use
vid_cycle  out  1  VID slots or last 4 CPU slots
cpu_cycle  out  1  CPU slots
ram_ce  out  1  SDRAM chip enable strobe
ram_we  out  1  SDRAM write
refresh  out  1  one-clock refresh request
enable_cpu  out  1  CPU clock enable
enable_vic  out  1  VIC clock enable
enable_io_p  out  1  phi2 rising enable
enable_io_n  out  1  phi2 falling enable
pulse_wr_io  out  1  registered IO write pulse
sys_reset  out  1  frame-aligned active-high reset to the system

Behaviour:
- Slot counter: 0..TOTAL-1, increments every clock, wraps TOTAL-1 -> 0.
  - EXT = [0, EXT_LEN)
  - VID = [EXT_LEN, EXT_LEN+VID_LEN)
  - CPU = remainder; c = slot-EXT_LEN-VID_LEN.
- reset_n low (synchronous):
  - slot=0, frame counter=0, rfsh_div latch=0, sys_reset=1.
  - All strobes (ram_ce, ram_we, refresh, enables, pulse_wr_io) = 0.
  - io_cycle=1, vid_cycle=0, cpu_cycle=0.
- sys_reset: sampled as ~reset_n only when frame_end; deasserts at the first frame boundary after reset_n returns high.
- Frame counter fc:
  - At frame_end: fc <= (fc==div_l) ? 0 : fc+1.
  - At the same edge, div_l <= rfsh_div. A mid-frame change therefore takes effect the next frame.
- refresh:
  - Registered one-clock pulse, asserted on the clock after slot RFSH_OFS-1 when fc==0.
  - It is high during slot RFSH_OFS.
- io_cycle (combinational from slot/fc):
  - High in all EXT slots, except slots [RFSH_OFS, RFSH_OFS+RFSH_LEN) when fc==0.
  - Low in VID and CPU slots.
- cpu_cycle: high in all CPU slots.
- vid_cycle: high in VID slots, and in CPU slots with c >= CPU_LEN-4.
- ram_ce (combinational):
  - High in slot EXT_LEN when vid_req.
  - High in CPU slot c==0 when cpu_req.
  - Otherwise low.
- ram_we = cpu_we & cpu_req & cpu_cycle.
- enable_cpu:
  - High for c==CPU_EN_OFS when cpu_rdy.
  - If cpu_rdy is low at that slot, no enable is issued this frame; the sequencer does not stall.
- enable_vic: high in the last VID slot and the last CPU slot.
- enable_io_p: high for c==IOP_OFS.
- enable_io_n:
  - High in slot 0.
  - Suppressed in the first frame after reset (a flag is set at the first frame_end).
- pulse_wr_io: registered; set for one clock on the edge leaving c==WR_OFS when cpu_we, so it is high in slot c==WR_OFS+1.
- Combinational strobes are functions of registered slot only; no input-to-output path except through cpu_req/cpu_we/vid_req/cpu_rdy gating.
- Elaboration check: reject any parameter set violating the ranges above.

Test Plan:
- Defaults, reset_n low 3 clocks then high: slot=0,1,2…31,0. enable_io_n absent at the first slot 0 and present at the second. sys_reset falls at the first frame_end after release.
- rfsh_div=3: refresh is high in slot 4 of frames 0,4,8 only. In those frames io_cycle is low in slots 4-7; in all other frames it is high in slots 0-11.
- rfsh_div changed 0->2 at slot 20: the next frame still refreshes (fc==0 path). Subsequent refreshes occur every 3rd frame.
- cpu_req=1, cpu_we=1, vid_req=1:
  - ram_ce high at slots 12 and 16.
  - ram_we high in slots 16-31.
  - pulse_wr_io high at slot 29.
  - enable_cpu at slot 18, enable_io_p at slot 29, enable_vic at slots 15 and 31.
- cpu_rdy=0 during slot 18 of one frame: no enable_cpu that frame. The next frame, with rdy=1, gives enable_cpu at slot 18; frame length stays 32.
- reset_n low at slot 20: at the next edge slot=0 and all strobes are 0; pulse_wr_io is not issued even if cpu_we=1.

Source files
------------

// File: rtl/cbm2_slot_sequencer.sv
// rtl/cbm2_slot_sequencer.sv - CBM-II system-cycle slot sequencer
//
// Divides clk_sys into a repeating frame of EXT, VID and CPU slots and
// derives the CPU/VIC/IO clock enables, SDRAM strobes and the refresh /
// io_cycle handshake from the current slot.
//
// Ports:
//   clk_sys, reset_n       clock, synchronous active-low reset
//   rfsh_div[3:0]          refresh every rfsh_div+1 frames (latched at frame end)
//   vid_req                video wants RAM this frame
//   cpu_req, cpu_we        CPU RAM access / write
//   cpu_rdy                low withholds enable_cpu for this frame
//   slot[SW-1:0]           current slot index
//   frame_end              last slot of the frame
//   io_cycle               SDRAM free for external/IO use
//   vid_cycle, cpu_cycle   slot region indicators
//   ram_ce, ram_we         SDRAM chip enable / write
//   refresh                one-clock refresh request
//   enable_cpu/vic/io_p/io_n  clock enables
//   pulse_wr_io            registered IO write pulse
//   sys_reset              frame-aligned active-high system reset
module cbm2_slot_sequencer #(
  parameter int EXT_LEN    = 12,
  parameter int VID_LEN    = 4,
  parameter int CPU_LEN    = 16,
  parameter int RFSH_OFS   = 4,
  parameter int RFSH_LEN   = 4,
  parameter int CPU_EN_OFS = 2,
  parameter int WR_OFS     = 12,
  parameter int IOP_OFS    = 13,
  localparam int TOTAL     = EXT_LEN + VID_LEN + CPU_LEN,
  localparam int SW        = $clog2(TOTAL)
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [3:0]    rfsh_div,
  input  logic          vid_req,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_rdy,
  output logic [SW-1:0] slot,
  output logic          frame_end,
  output logic          io_cycle,
  output logic          vid_cycle,
  output logic          cpu_cycle,
  output logic          ram_ce,
  output logic          ram_we,
  output logic          refresh,
  output logic          enable_cpu,
  output logic          enable_vic,
  output logic          enable_io_p,
  output logic          enable_io_n,
  output logic          pulse_wr_io,
  output logic          sys_reset
);

  if (EXT_LEN < 1 || VID_LEN < 1 || CPU_LEN < 4 ||
      RFSH_OFS < 1 || RFSH_LEN < 1 || RFSH_OFS + RFSH_LEN > EXT_LEN ||
      CPU_EN_OFS < 0 || CPU_EN_OFS >= CPU_LEN ||
      WR_OFS < 0 || WR_OFS >= CPU_LEN ||
      IOP_OFS < 0 || IOP_OFS >= CPU_LEN) begin : g_bad_params
    $error("cbm2_slot_sequencer: illegal parameter set");
  end

  localparam logic [SW-1:0] S_LAST     = SW'(TOTAL - 1);
  localparam logic [SW-1:0] S_VID      = SW'(EXT_LEN);
  localparam logic [SW-1:0] S_VID_LAST = SW'(EXT_LEN + VID_LEN - 1);
  localparam logic [SW-1:0] S_CPU      = SW'(EXT_LEN + VID_LEN);
  localparam logic [SW-1:0] S_RFSH_PRE = SW'(RFSH_OFS - 1);
  localparam logic [SW-1:0] S_RFSH     = SW'(RFSH_OFS);
  localparam logic [SW-1:0] S_RFSH_END = SW'(RFSH_OFS + RFSH_LEN);
  localparam logic [SW-1:0] C_VIDTAIL  = SW'(CPU_LEN - 4);
  localparam logic [SW-1:0] C_EN       = SW'(CPU_EN_OFS);
  localparam logic [SW-1:0] C_WR       = SW'(WR_OFS);
  localparam logic [SW-1:0] C_IOP      = SW'(IOP_OFS);

  logic [3:0]    fc;
  logic [3:0]    div_l;
  logic          io_n_armed;
  logic          in_ext;
  logic          in_vid;
  logic          in_cpu;
  logic          rfsh_frame;
  logic [SW-1:0] c;

  assign in_ext     = (slot < S_VID);
  assign in_vid     = (slot >= S_VID) && (slot < S_CPU);
  assign in_cpu     = (slot >= S_CPU);
  // CPU-relative slot index; only meaningful while in_cpu.
  assign c          = slot - S_CPU;
  assign rfsh_frame = (fc == 4'd0);

  assign frame_end   = (slot == S_LAST);
  assign io_cycle    = in_ext && !(rfsh_frame && slot >= S_RFSH && slot < S_RFSH_END);
  assign cpu_cycle   = in_cpu;
  assign vid_cycle   = in_vid || (in_cpu && c >= C_VIDTAIL);
  assign ram_ce      = (slot == S_VID && vid_req) || (slot == S_CPU && cpu_req);
  assign ram_we      = cpu_we && cpu_req && in_cpu;
  // A missed enable is simply dropped; the frame never stretches.
  assign enable_cpu  = in_cpu && (c == C_EN) && cpu_rdy;
  assign enable_vic  = (slot == S_VID_LAST) || (slot == S_LAST);
  assign enable_io_p = in_cpu && (c == C_IOP);
  assign enable_io_n = (slot == '0) && io_n_armed;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      slot        <= '0;
      fc          <= '0;
      div_l       <= '0;
      sys_reset   <= 1'b1;
      refresh     <= 1'b0;
      pulse_wr_io <= 1'b0;
      io_n_armed  <= 1'b0;
    end else begin
      slot        <= frame_end ? '0 : slot + SW'(1);
      refresh     <= (slot == S_RFSH_PRE) && rfsh_frame;
      pulse_wr_io <= in_cpu && (c == C_WR) && cpu_we;
      if (frame_end) begin
        // The divider is latched here so a mid-frame change applies next frame.
        fc         <= (fc == div_l) ? 4'd0 : fc + 4'd1;
        div_l      <= rfsh_div;
        sys_reset  <= 1'b0;
        io_n_armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cbm2_slot_sequencer.sv
// tb/tb_cbm2_slot_sequencer.sv - self-checking bench for cbm2_slot_sequencer
module tb_cbm2_slot_sequencer;

  localparam int EXT = 12, VID = 4, CPU = 16, TOT = 32;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [3:0] rfsh_div;
  logic       vid_req, cpu_req, cpu_we, cpu_rdy;
  logic [4:0] slot;
  logic frame_end, io_cycle, vid_cycle, cpu_cycle, ram_ce, ram_we, refresh;
  logic enable_cpu, enable_vic, enable_io_p, enable_io_n, pulse_wr_io, sys_reset;

  cbm2_slot_sequencer dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .rfsh_div(rfsh_div),
    .vid_req(vid_req), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy),
    .slot(slot), .frame_end(frame_end), .io_cycle(io_cycle),
    .vid_cycle(vid_cycle), .cpu_cycle(cpu_cycle), .ram_ce(ram_ce),
    .ram_we(ram_we), .refresh(refresh), .enable_cpu(enable_cpu),
    .enable_vic(enable_vic), .enable_io_p(enable_io_p),
    .enable_io_n(enable_io_n), .pulse_wr_io(pulse_wr_io),
    .sys_reset(sys_reset)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Reference model state: frame position plus frame-level bookkeeping.
  int m_slot, m_fc, m_divl;
  bit m_sys, m_armed, m_pwr, m_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (slot %0d)", name, act, exp, m_slot);
    end
  endtask

  // Bit order: frame_end io vid cpu ce we refresh en_cpu en_vic io_p io_n pwr sys_reset
  function automatic logic [12:0] dut_vec();
    return {frame_end, io_cycle, vid_cycle, cpu_cycle, ram_ce, ram_we, refresh,
            enable_cpu, enable_vic, enable_io_p, enable_io_n, pulse_wr_io, sys_reset};
  endfunction

  function automatic logic [12:0] exp_vec();
    bit ext, vid, cpu;
    int c;
    ext = m_slot < EXT;
    vid = m_slot >= EXT && m_slot < EXT + VID;
    cpu = m_slot >= EXT + VID;
    c = m_slot - (EXT + VID);
    return {m_slot == TOT - 1,
            ext && !(m_fc == 0 && m_slot >= 4 && m_slot < 8),
            vid || (cpu && c >= CPU - 4),
            cpu,
            (m_slot == EXT && vid_req) || (m_slot == EXT + VID && cpu_req),
            cpu_we && cpu_req && cpu,
            m_slot == 4 && m_fc == 0,
            cpu && c == 2 && cpu_rdy,
            m_slot == EXT + VID - 1 || m_slot == TOT - 1,
            cpu && c == 13,
            m_slot == 0 && m_armed,
            m_pwr,
            m_sys};
  endfunction

  task automatic at_neg();
    @(negedge clk_sys);
    if (m_valid) begin
      chk("model_slot", 32'(slot), 32'(m_slot));
      chk("model_outputs", 32'(dut_vec()), 32'(exp_vec()));
    end
  endtask

  task automatic at_pos();
    @(posedge clk_sys);
    if (!reset_n) begin
      m_slot = 0; m_fc = 0; m_divl = 0; m_sys = 1; m_armed = 0; m_pwr = 0;
      m_valid = 1;
    end else begin
      m_pwr = (m_slot == EXT + VID + 12) && cpu_we;
      if (m_slot == TOT - 1) begin
        m_fc = (m_fc == m_divl) ? 0 : (m_fc + 1) % 16;
        m_divl = int'(rfsh_div);
        m_sys = 0;
        m_armed = 1;
      end
      m_slot = (m_slot + 1) % TOT;
    end
    #1;
  endtask

  task automatic tick();
    at_neg();
    at_pos();
  endtask

  task automatic goto_slot(input int s);
    int n = 0;
    while (m_slot != s && n < 64) begin tick(); n++; end
    chk("goto_slot_reached", 32'(m_slot == s), 32'd1);
  endtask

  typedef struct {
    int          cyc;
    logic [4:0]  exp_slot;
    logic [12:0] exp_out;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int seen, last_fe, gap, n;
    tbl[0]  = '{0,  5'd0,  13'b0100000000001};
    tbl[1]  = '{4,  5'd4,  13'b0000001000001};
    tbl[2]  = '{8,  5'd8,  13'b0100000000001};
    tbl[3]  = '{12, 5'd12, 13'b0010100000001};
    tbl[4]  = '{15, 5'd15, 13'b0010000010001};
    tbl[5]  = '{16, 5'd16, 13'b0001110000001};
    tbl[6]  = '{18, 5'd18, 13'b0001010100001};
    tbl[7]  = '{28, 5'd28, 13'b0011010000001};
    tbl[8]  = '{29, 5'd29, 13'b0011010001011};
    tbl[9]  = '{31, 5'd31, 13'b1011010010001};
    tbl[10] = '{32, 5'd0,  13'b0100000000100};
    tbl[11] = '{36, 5'd4,  13'b0000001000000};

    reset_n = 0; rfsh_div = 0; vid_req = 0; cpu_req = 0; cpu_we = 0; cpu_rdy = 1;
    #1;
    repeat (3) tick();
    cpu_req = 1; cpu_we = 1; vid_req = 1; reset_n = 1;

    // Table: first frames after reset release with all requests active.
    for (int cyc = 0; cyc <= 36; cyc++) begin
      at_neg();
      for (int i = 0; i < 12; i++)
        if (tbl[i].cyc == cyc) begin
          chk("tbl_slot", 32'(slot), 32'(tbl[i].exp_slot));
          chk("tbl_outputs", 32'(dut_vec()), 32'(tbl[i].exp_out));
        end
      at_pos();
    end

    // rfsh_div=3: latched at the end of this frame, refresh every 4th frame after.
    rfsh_div = 3;
    goto_slot(0);
    for (int f = 0; f < 8; f++) begin
      seen = 0;
      for (int s = 0; s < TOT; s++) begin at_neg(); if (refresh) seen++; at_pos(); end
      chk("rfsh_div3_frame", 32'(seen), 32'(f % 4 == 0));
    end

    // Return to a refreshing frame with divider 0, then change 0->2 mid-frame.
    rfsh_div = 0;
    n = 0;
    while (!(m_slot == 0 && m_fc == 0 && m_divl == 0) && n < 1200) begin tick(); n++; end
    chk("rfsh_resync", 32'(m_slot == 0 && m_fc == 0 && m_divl == 0), 32'd1);
    goto_slot(20);
    rfsh_div = 2;
    goto_slot(0);
    for (int f = 0; f < 7; f++) begin
      seen = 0;
      for (int s = 0; s < TOT; s++) begin at_neg(); if (refresh) seen++; at_pos(); end
      chk("rfsh_div2_frame", 32'(seen), 32'(f % 3 == 0));
    end

    // Wait state at slot 18: enable dropped, next frame's enable 32 clocks later.
    goto_slot(18);
    cpu_rdy = 0;
    at_neg();
    chk("rdy_low_no_enable", 32'(enable_cpu), 32'd0);
    at_pos();
    cpu_rdy = 1;
    gap = 1; last_fe = -1; n = 0;
    while (n < 40) begin
      at_neg();
      if (frame_end) last_fe = n;
      if (enable_cpu) break;
      at_pos();
      gap++; n++;
    end
    chk("rdy_next_enable_gap", 32'(gap), 32'd32);
    chk("rdy_frame_end_pos", 32'(last_fe), 32'd12);
    at_pos();

    // Reset at slot 20 held past the write slot: counter parked, no strobes.
    goto_slot(20);
    cpu_we = 1;
    reset_n = 0;
    tick();
    for (int k = 0; k < 12; k++) begin
      at_neg();
      chk("rst_slot_zero", 32'(slot), 32'd0);
      chk("rst_strobes", 32'({ram_ce, ram_we, refresh, enable_cpu, enable_vic,
                              enable_io_p, enable_io_n, pulse_wr_io}), 32'd0);
      chk("rst_cycles", 32'({io_cycle, vid_cycle, cpu_cycle, sys_reset}), 32'b1001);
      at_pos();
    end
    reset_n = 1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cpu_req = 1'($urandom);
      cpu_we  = 1'($urandom);
      vid_req = 1'($urandom);
      cpu_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) rfsh_div = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 299) == 0) reset_n = 0;
      else if (!reset_n && $urandom_range(0, 2) == 0) reset_n = 1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
